// File: rtl/ps2_key_tx.sv
// PS/2 device-side key transmitter: key event -> [E0] [F0] code frames.
// Ports: clk/rstn, key_* request (valid/ready), host_inhibit, PS2_CLK/PS2_DATA, busy, frame_done, seq_done.
module ps2_key_tx #(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_break,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       host_inhibit,
  output logic       PS2_CLK,
  output logic       PS2_DATA,
  output logic       busy,
  output logic       frame_done,
  output logic       seq_done
);

  localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, BIT_H, BIT_L, GAP, ABORT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_idx;
  logic [10:0]     frm;
  logic [3:0][7:0] seq;
  logic [1:0]      nbytes;
  logic [1:0]      bidx;
  logic [3:0][7:0] lst;
  logic [1:0]      lst_n;
  logic            accept;

  function automatic logic [10:0] mkframe(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // seq_done cycle is already IDLE; keep ready low so it never
  // coincides with an accept.
  assign key_ready = (state == IDLE) & ~host_inhibit & ~seq_done;
  assign accept    = key_valid & key_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    lst   = '0;
    lst_n = 2'd1;
    case ({key_ext, key_break})
      2'b00: begin
        lst[0] = key_code;
        lst_n  = 2'd1;
      end
      2'b01: begin
        lst[0] = 8'hF0;
        lst[1] = key_code;
        lst_n  = 2'd2;
      end
      2'b10: begin
        lst[0] = 8'hE0;
        lst[1] = key_code;
        lst_n  = 2'd2;
      end
      default: begin
        lst[0] = 8'hE0;
        lst[1] = 8'hF0;
        lst[2] = key_code;
        lst_n  = 2'd3;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      frm        <= '1;
      seq        <= '0;
      nbytes     <= '0;
      bidx       <= '0;
      PS2_CLK    <= 1'b1;
      PS2_DATA   <= 1'b1;
      frame_done <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      seq_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            seq      <= lst;
            nbytes   <= lst_n;
            bidx     <= '0;
            frm      <= mkframe(lst[0]);
            bit_idx  <= '0;
            cnt      <= '0;
            PS2_CLK  <= 1'b1;
            PS2_DATA <= 1'b0;
            state    <= BIT_H;
          end
        end
        BIT_H, BIT_L: begin
          // Stop bit is never cut short; inhibit is seen at next BIT_H.
          if (host_inhibit && bit_idx != 4'd10) begin
            state    <= ABORT;
            cnt      <= '0;
            bit_idx  <= '0;
            PS2_CLK  <= 1'b1;
            PS2_DATA <= 1'b1;
          end else if (cnt != DIV_END) begin
            cnt <= cnt + 1'b1;
          end else if (state == BIT_H) begin
            cnt     <= '0;
            PS2_CLK <= 1'b0;
            state   <= BIT_L;
          end else if (bit_idx != 4'd10) begin
            cnt      <= '0;
            PS2_CLK  <= 1'b1;
            bit_idx  <= bit_idx + 4'd1;
            PS2_DATA <= frm[bit_idx + 4'd1];
            state    <= BIT_H;
          end else begin
            cnt        <= '0;
            PS2_CLK    <= 1'b1;
            PS2_DATA   <= 1'b1;
            frame_done <= 1'b1;
            bidx       <= bidx + 2'd1;
            state      <= GAP;
          end
        end
        GAP: begin
          if (!host_inhibit) begin
            if (cnt != GAP_END) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              // bidx only advances on a completed frame, so an
              // aborted byte is resent from here.
              if (bidx < nbytes) begin
                frm      <= mkframe(seq[bidx]);
                bit_idx  <= '0;
                PS2_DATA <= 1'b0;
                state    <= BIT_H;
              end else begin
                seq_done <= 1'b1;
                state    <= IDLE;
              end
            end
          end
        end
        ABORT: begin
          if (!host_inhibit) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tx.sv
// Directed bench for ps2_key_tx with a falling-edge PS/2 line decoder.
// CLK_DIV=2, GAP_CYCLES=4: 44 cycles per frame, 4 gap cycles.
module tb_ps2_key_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] key_code = '0;
  logic       key_ext = 1'b0;
  logic       key_break = 1'b0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic       host_inhibit = 1'b0;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       busy;
  logic       frame_done;
  logic       seq_done;

  int checks = 0;
  int failures = 0;

  logic [10:0] frames[$];

  ps2_key_tx #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn),
    .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_valid(key_valid),
    .key_ready(key_ready), .host_inhibit(host_inhibit),
    .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .busy(busy), .frame_done(frame_done),
    .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  // Receiver model: sample data on PS2_CLK falls; a long high
  // stretch resynchronises, like a real host timeout.
  initial begin : decoder
    logic [10:0] sh;
    int nb;
    int hi;
    logic pd;
    sh = '0; nb = 0; hi = 0; pd = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        nb = 0; hi = 0; pd = 1'b1;
      end else begin
        if (PS2_CLK) hi++;
        else hi = 0;
        if (hi >= 5) nb = 0;
        if (pd && !PS2_CLK) begin
          sh[nb] = PS2_DATA;
          nb++;
          if (nb == 11) begin
            frames.push_back(sh);
            nb = 0;
          end
        end
        pd = PS2_CLK;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] c,
                          input logic e, input logic b);
    int w;
    w = 0;
    while (!key_ready && w < 1000) begin
      step();
      w++;
    end
    key_code = c; key_ext = e; key_break = b;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  // Observe from the first BIT_H cycle (t=0) to the seq_done cycle.
  task automatic run_seq(output int nfd, output int tfd,
                         output int tsd, output int nbusy);
    nfd = 0; tfd = -1; tsd = -1; nbusy = 0;
    for (int t = 0; t < 2000; t++) begin
      if (frame_done) begin
        if (nfd == 0) tfd = t;
        nfd++;
      end
      if (busy) nbusy++;
      if (seq_done) begin
        tsd = t;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    host_inhibit = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_inh got=%b exp=0", key_ready);
    end
    host_inhibit = 1'b0;
    step(); step();
    checks++;
    if ({PS2_CLK, PS2_DATA, busy, frame_done, seq_done, key_ready}
        !== 6'b110001) begin
      failures++;
      $display("FAIL reset_state got=%b exp=110001",
               {PS2_CLK, PS2_DATA, busy, frame_done, seq_done, key_ready});
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int nfd, tfd, tsd, nb;
    frames.delete();
    send_key(8'h1C, 1'b0, 1'b0);
    run_seq(nfd, tfd, tsd, nb);
    checks++;
    if (tfd !== 44) begin
      failures++;
      $display("FAIL single_fd_time got=%0d exp=44", tfd);
    end
    checks++;
    if (tsd !== 48) begin
      failures++;
      $display("FAIL single_sd_time got=%0d exp=48", tsd);
    end
    checks++;
    if ({key_ready, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_sd_ready got=%b exp=00", {key_ready, busy});
    end
    step();
    checks++;
    if (frames.size() !== 1) begin
      failures++;
      $display("FAIL single_nframes got=%0d exp=1", frames.size());
    end else begin
      checks++;
      if (frames[0] !== 11'h438) begin
        failures++;
        $display("FAIL single_frame got=%h exp=438", frames[0]);
      end
    end
  endtask

  task automatic test_ext_break();
    int nfd, tfd, tsd, nb;
    logic [10:0] exp_f[3];
    exp_f[0] = 11'h5C0;
    exp_f[1] = 11'h7E0;
    exp_f[2] = 11'h4EA;
    frames.delete();
    send_key(8'h75, 1'b1, 1'b1);
    run_seq(nfd, tfd, tsd, nb);
    checks++;
    if (nfd !== 3) begin
      failures++;
      $display("FAIL ext_nfd got=%0d exp=3", nfd);
    end
    checks++;
    if (tsd !== 144 || nb !== 144) begin
      failures++;
      $display("FAIL ext_busy got_sd=%0d got_busy=%0d exp=144", tsd, nb);
    end
    step();
    checks++;
    if (frames.size() !== 3) begin
      failures++;
      $display("FAIL ext_nframes got=%0d exp=3", frames.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (frames[i] !== exp_f[i]) begin
          failures++;
          $display("FAIL ext_frame%0d got=%h exp=%h", i, frames[i], exp_f[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad, seen, nfd, tfd, tsd, nb;
    bad = 0; seen = 0;
    frames.delete();
    send_key(8'h1C, 1'b0, 1'b0);
    key_code = 8'h16;
    key_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      if (key_ready) bad++;
      if (seq_done) begin
        seen = 1;
        break;
      end
      step();
    end
    checks++;
    if (seen !== 1 || bad !== 0) begin
      failures++;
      $display("FAIL b2b_blocked got_seen=%0d got_ready=%0d exp=1/0", seen, bad);
    end
    step();
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_after got=%b exp=1", key_ready);
    end
    step();
    key_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept got=%b exp=1", busy);
    end
    run_seq(nfd, tfd, tsd, nb);
    step();
    checks++;
    if (frames.size() !== 2) begin
      failures++;
      $display("FAIL b2b_nframes got=%0d exp=2", frames.size());
    end else begin
      checks++;
      if (frames[0] !== 11'h438 || frames[1] !== 11'h42C) begin
        failures++;
        $display("FAIL b2b_frames got=%h,%h exp=438,42c", frames[0], frames[1]);
      end
    end
  endtask

  task automatic test_inhibit_abort();
    int fdc, nfd, tfd, tsd, nb;
    fdc = 0;
    frames.delete();
    send_key(8'h1C, 1'b0, 1'b0);
    repeat (18) step();
    checks++;
    if (PS2_CLK !== 1'b0) begin
      failures++;
      $display("FAIL inh_pre_low got=%b exp=0", PS2_CLK);
    end
    host_inhibit = 1'b1;
    step();
    checks++;
    if ({PS2_CLK, PS2_DATA, busy} !== 3'b111) begin
      failures++;
      $display("FAIL inh_lines_high got=%b exp=111", {PS2_CLK, PS2_DATA, busy});
    end
    repeat (9) begin
      if (frame_done) fdc++;
      step();
    end
    host_inhibit = 1'b0;
    run_seq(nfd, tfd, tsd, nb);
    step();
    checks++;
    if (fdc + nfd !== 1 || tsd < 0) begin
      failures++;
      $display("FAIL inh_frame_done got=%0d exp=1", fdc + nfd);
    end
    checks++;
    if (frames.size() !== 1) begin
      failures++;
      $display("FAIL inh_nframes got=%0d exp=1", frames.size());
    end else begin
      checks++;
      if (frames[0] !== 11'h438) begin
        failures++;
        $display("FAIL inh_frame got=%h exp=438", frames[0]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int nfd, tfd, tsd, nb;
    send_key(8'h1C, 1'b0, 1'b0);
    repeat (26) step();
    checks++;
    if ({PS2_CLK, PS2_DATA} !== 2'b00) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=00", {PS2_CLK, PS2_DATA});
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({PS2_CLK, PS2_DATA, busy} !== 3'b110) begin
      failures++;
      $display("FAIL rst_async got=%b exp=110", {PS2_CLK, PS2_DATA, busy});
    end
    step(); step();
    rstn = 1'b1;
    step();
    frames.delete();
    send_key(8'h29, 1'b0, 1'b0);
    run_seq(nfd, tfd, tsd, nb);
    step();
    checks++;
    if (frames.size() !== 1) begin
      failures++;
      $display("FAIL rst_nframes got=%0d exp=1", frames.size());
    end else begin
      checks++;
      if (frames[0] !== 11'h452) begin
        failures++;
        $display("FAIL rst_frame got=%h exp=452", frames[0]);
      end
    end
  endtask

  task automatic test_idle_inhibit();
    int act;
    act = 0;
    host_inhibit = 1'b1;
    key_code = 8'h1C;
    key_valid = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_inh_ready got=%b exp=0", key_ready);
    end
    repeat (8) begin
      step();
      if (!PS2_CLK || busy) act++;
    end
    checks++;
    if (act !== 0) begin
      failures++;
      $display("FAIL idle_inh_quiet got=%0d exp=0", act);
    end
    key_valid = 1'b0;
    host_inhibit = 1'b0;
    #1;
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_inh_release got=%b exp=1", key_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ext_break();
    test_back_to_back();
    test_inhibit_abort();
    test_reset_midframe();
    test_idle_inhibit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
